// File: rtl/pseudo_cpu_pkg.sv
// Shared widths, opcode encodings and the ALU operation type for the PseudoCPU.
package pseudo_cpu_pkg;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 4;
   localparam int INSTR_W = 8;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SWP = 4'h3;
   localparam logic [3:0] OP_MVB = 4'h4;
   localparam logic [3:0] OP_SHR = 4'h5;
   localparam logic [3:0] OP_SHL = 4'h6;
   localparam logic [3:0] OP_CLR = 4'h7;
   localparam logic [3:0] OP_INC = 4'h8;
   localparam logic [3:0] OP_DEC = 4'h9;
   localparam logic [3:0] OP_TST = 4'hA;
   localparam logic [3:0] OP_JZ  = 4'hB;
   localparam logic [3:0] OP_JNZ = 4'hC;
   localparam logic [3:0] OP_JMP = 4'hD;
   localparam logic [3:0] OP_RSV = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [3:0] {
      ALU_NONE, ALU_SUB, ALU_ADD, ALU_SWP, ALU_MVB, ALU_SHR,
      ALU_SHL, ALU_CLR, ALU_INC, ALU_DEC, ALU_TST
   } alu_op_t;
endpackage

// File: rtl/pseudo_cpu_if.sv
// Control-to-datapath link: decoded ALU op and register enables out, zero result back.
interface pseudo_cpu_if import pseudo_cpu_pkg::*; ();
   alu_op_t alu_op;
   logic    we_a;
   logic    we_b;
   logic    zero;

   modport master (output alu_op, we_a, we_b, input zero);
   modport slave  (input alu_op, we_a, we_b, output zero);
endinterface

// File: rtl/pseudo_cpu_control.sv
// PseudoCPU control unit: instruction memory, program counter, zero flag, halt and decode.
module control import pseudo_cpu_pkg::*; (
   input  logic         clk,
   input  logic         rst,
   pseudo_cpu_if.master bus
);
   reg   [INSTR_W-1:0] imem [0:2**ADDR_W-1];
   logic [ADDR_W-1:0]  addr;
   logic               z;
   logic               halted;

   logic [INSTR_W-1:0] w_instr;
   logic [3:0]         w_opc;
   logic [ADDR_W-1:0]  w_k;
   alu_op_t            w_op;
   logic               w_we_a;
   logic               w_we_b;
   logic               w_z_upd;

   assign w_instr = imem[addr];
   assign w_opc   = w_instr[7:4];
   assign w_k     = w_instr[ADDR_W-1:0];

   always_comb begin
      w_op    = ALU_NONE;
      w_we_a  = 1'b0;
      w_we_b  = 1'b0;
      w_z_upd = 1'b0;
      case (w_opc)
         OP_SUB: begin w_op = ALU_SUB; w_we_a = 1'b1; w_z_upd = 1'b1; end
         OP_ADD: begin w_op = ALU_ADD; w_we_a = 1'b1; w_z_upd = 1'b1; end
         OP_SWP: begin w_op = ALU_SWP; w_we_a = 1'b1; w_we_b = 1'b1; end
         OP_MVB: begin w_op = ALU_MVB; w_we_b = 1'b1; end
         OP_SHR: begin w_op = ALU_SHR; w_we_a = 1'b1; w_z_upd = 1'b1; end
         OP_SHL: begin w_op = ALU_SHL; w_we_a = 1'b1; w_z_upd = 1'b1; end
         OP_CLR: begin w_op = ALU_CLR; w_we_a = 1'b1; w_z_upd = 1'b1; end
         OP_INC: begin w_op = ALU_INC; w_we_a = 1'b1; w_z_upd = 1'b1; end
         OP_DEC: begin w_op = ALU_DEC; w_we_a = 1'b1; w_z_upd = 1'b1; end
         OP_TST: begin w_op = ALU_TST; w_z_upd = 1'b1; end
         default: ;
      endcase
   end

   // Halt freezes the datapath by killing both register enables.
   assign bus.alu_op = w_op;
   assign bus.we_a   = w_we_a & ~halted;
   assign bus.we_b   = w_we_b & ~halted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr   <= '0;
         z      <= 1'b0;
         halted <= 1'b0;
      end else if (!halted) begin
         if (w_z_upd) z <= bus.zero;
         case (w_opc)
            OP_JZ:   addr <= z  ? w_k : addr + 1'b1;
            OP_JNZ:  addr <= !z ? w_k : addr + 1'b1;
            OP_JMP:  addr <= w_k;
            OP_HLT:  halted <= 1'b1;
            default: addr <= addr + 1'b1;
         endcase
      end
   end
endmodule

// File: rtl/pseudo_cpu_top.sv
// PseudoCPU top: data registers a/b and the ALU, driven by the control unit.
module pseudo_cpu_top import pseudo_cpu_pkg::*; (
   input logic clk,
   input logic rst
);
   reg   [DATA_W-1:0] a;
   reg   [DATA_W-1:0] b;
   logic [DATA_W-1:0] w_result;

   pseudo_cpu_if bus ();

   control ctrl (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // w_result is the next value of a; TST routes a through so the zero detect sees it.
   always_comb begin
      w_result = a;
      case (bus.alu_op)
         ALU_SUB: w_result = a - b;
         ALU_ADD: w_result = a + b;
         ALU_SWP: w_result = b;
         ALU_SHR: w_result = a >> 1;
         ALU_SHL: w_result = a << 1;
         ALU_CLR: w_result = '0;
         ALU_INC: w_result = a + 1'b1;
         ALU_DEC: w_result = a - 1'b1;
         default: w_result = a;
      endcase
   end

   assign bus.zero = (w_result == '0);

   // No reset on a/b so values loaded during reset survive; rst only blocks the write.
   always @(posedge clk) begin
      if (!rst && bus.we_a) a <= w_result;
      if (!rst && bus.we_b) b <= a;
   end
endmodule

// File: tb/tb_pseudo_cpu_top.sv
// Self-checking bench for pseudo_cpu_top against an instruction-level reference model.
module tb_pseudo_cpu_top;
   import pseudo_cpu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [31:0] m_a, m_b;
   logic [3:0]  m_pc;
   logic        m_z, m_halt;
   logic [7:0]  m_imem [16];

   pseudo_cpu_top dut (.clk(clk), .rst(rst));

   always #5 clk = ~clk;

   // One instruction of the architectural machine.
   task automatic model_step();
      logic [7:0]  ins;
      logic [3:0]  opc;
      logic [3:0]  k;
      logic [31:0] t;
      int          nxt;
      if (m_halt) return;
      ins = m_imem[m_pc];
      opc = ins[7:4];
      k   = ins[3:0];
      nxt = (int'(m_pc) + 1) % 16;
      case (opc)
         4'h1: begin m_a = m_a - m_b;  m_z = (m_a == 0); end
         4'h2: begin m_a = m_a + m_b;  m_z = (m_a == 0); end
         4'h3: begin t = m_a; m_a = m_b; m_b = t; end
         4'h4: m_b = m_a;
         4'h5: begin m_a = m_a >> 1;   m_z = (m_a == 0); end
         4'h6: begin m_a = m_a << 1;   m_z = (m_a == 0); end
         4'h7: begin m_a = 0;          m_z = 1'b1; end
         4'h8: begin m_a = m_a + 1;    m_z = (m_a == 0); end
         4'h9: begin m_a = m_a - 1;    m_z = (m_a == 0); end
         4'hA: m_z = (m_a == 0);
         4'hB: if (m_z)  nxt = int'(k);
         4'hC: if (!m_z) nxt = int'(k);
         4'hD: nxt = int'(k);
         4'hF: begin m_halt = 1'b1; nxt = int'(m_pc); end
         default: ;
      endcase
      m_pc = 4'(nxt);
   endtask

   task automatic load(input logic [7:0] prog[$], input logic [31:0] va, input logic [31:0] vb);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         m_imem[i] = (i < prog.size()) ? prog[i] : 8'h00;
         dut.ctrl.imem[i] = m_imem[i];
      end
      dut.a = va;
      dut.b = vb;
      m_a = va; m_b = vb; m_pc = 4'd0; m_z = 1'b0; m_halt = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      dut.a = 32'd4123481;
      dut.b = 32'd9402102;
      repeat (10) @(posedge clk);
      #1;
      n_checks++;
      if (dut.ctrl.addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", dut.ctrl.addr); end
      n_checks++;
      if (dut.ctrl.z !== 1'b0) begin n_fail++; $display("FAIL reset_z: got %b expected 0", dut.ctrl.z); end
      n_checks++;
      if (dut.ctrl.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", dut.ctrl.halted); end
      n_checks++;
      if (dut.a !== 32'd4123481) begin n_fail++; $display("FAIL reset_a: got %0d expected 4123481", dut.a); end
      n_checks++;
      if (dut.b !== 32'd9402102) begin n_fail++; $display("FAIL reset_b: got %0d expected 9402102", dut.b); end
   endtask

   task automatic test_sub_wrap();
      logic [7:0] p[$];
      p = '{{OP_SUB, 4'h0}, {OP_HLT, 4'h0}};
      load(p, 32'd4123481, 32'd9402102);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); model_step(); #1;
         n_checks++;
         if ({dut.a, dut.b, dut.ctrl.addr, dut.ctrl.z, dut.ctrl.halted} !== {m_a, m_b, m_pc, m_z, m_halt}) begin
            n_fail++;
            $display("FAIL sub_wrap_state cyc %0d: got %h expected %h", c,
                     {dut.a, dut.b, dut.ctrl.addr, dut.ctrl.z, dut.ctrl.halted}, {m_a, m_b, m_pc, m_z, m_halt});
         end
         n_checks++;
         if (dut.a !== 32'd4289688675 || dut.ctrl.z !== 1'b0 || dut.ctrl.addr !== 4'd1) begin
            n_fail++;
            $display("FAIL sub_wrap_const cyc %0d: got a=%0d z=%b addr=%0d expected a=4289688675 z=0 addr=1",
                     c, dut.a, dut.ctrl.z, dut.ctrl.addr);
         end
      end
   endtask

   task automatic test_equality_loop();
      logic [7:0] p[$];
      p = '{{OP_SUB, 4'h0}, {OP_JZ, 4'h4}, {OP_JMP, 4'h0}, {OP_NOP, 4'h0}, {OP_HLT, 4'h0}};
      load(p, 32'd9402102, 32'd9402102);
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); model_step(); #1;
         n_checks++;
         if ({dut.a, dut.b, dut.ctrl.addr, dut.ctrl.z, dut.ctrl.halted} !== {m_a, m_b, m_pc, m_z, m_halt}) begin
            n_fail++;
            $display("FAIL eq_loop_state cyc %0d: got %h expected %h", c,
                     {dut.a, dut.b, dut.ctrl.addr, dut.ctrl.z, dut.ctrl.halted}, {m_a, m_b, m_pc, m_z, m_halt});
         end
         if (c == 1) begin
            n_checks++;
            if (dut.a !== 32'd0 || dut.ctrl.z !== 1'b1) begin
               n_fail++; $display("FAIL eq_loop_c1: got a=%0d z=%b expected a=0 z=1", dut.a, dut.ctrl.z);
            end
         end else begin
            n_checks++;
            if (dut.ctrl.addr !== 4'd4) begin
               n_fail++; $display("FAIL eq_loop_addr cyc %0d: got %0d expected 4", c, dut.ctrl.addr);
            end
         end
      end
      n_checks++;
      if (dut.ctrl.halted !== 1'b1) begin n_fail++; $display("FAIL eq_loop_halt: got %b expected 1", dut.ctrl.halted); end
   endtask

   task automatic test_countdown();
      logic [7:0] p[$];
      p = '{{OP_DEC, 4'h0}, {OP_JNZ, 4'h0}, {OP_HLT, 4'h0}};
      load(p, 32'd3, 32'd77);
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); model_step(); #1;
         n_checks++;
         if ({dut.a, dut.b, dut.ctrl.addr, dut.ctrl.z, dut.ctrl.halted} !== {m_a, m_b, m_pc, m_z, m_halt}) begin
            n_fail++;
            $display("FAIL countdown_state cyc %0d: got %h expected %h", c,
                     {dut.a, dut.b, dut.ctrl.addr, dut.ctrl.z, dut.ctrl.halted}, {m_a, m_b, m_pc, m_z, m_halt});
         end
      end
      n_checks++;
      if (dut.a !== 32'd0 || dut.ctrl.z !== 1'b1 || dut.ctrl.addr !== 4'd2 || dut.ctrl.halted !== 1'b1) begin
         n_fail++;
         $display("FAIL countdown_end: got a=%0d z=%b addr=%0d halted=%b expected a=0 z=1 addr=2 halted=1",
                  dut.a, dut.ctrl.z, dut.ctrl.addr, dut.ctrl.halted);
      end
   endtask

   task automatic test_pc_wrap();
      logic [7:0]  p[$];
      logic [31:0] va, vb;
      va = $urandom; vb = $urandom;
      p = {};
      load(p, va, vb);
      for (int c = 1; c <= 18; c++) begin
         @(posedge clk); model_step(); #1;
         n_checks++;
         if (dut.ctrl.addr !== 4'(c % 16) || dut.a !== va || dut.b !== vb) begin
            n_fail++;
            $display("FAIL pc_wrap cyc %0d: got addr=%0d a=%h b=%h expected addr=%0d a=%h b=%h",
                     c, dut.ctrl.addr, dut.a, dut.b, c % 16, va, vb);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] p[$];
      p = {};
      for (int i = 0; i < 7; i++) p.push_back({4'($urandom_range(1, 10)), 4'($urandom)});
      load(p, $urandom, $urandom);
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk); model_step(); #1;
         n_checks++;
         if ({dut.a, dut.b, dut.ctrl.addr, dut.ctrl.z} !== {m_a, m_b, m_pc, m_z}) begin
            n_fail++;
            $display("FAIL async_pre cyc %0d: got %h expected %h", c,
                     {dut.a, dut.b, dut.ctrl.addr, dut.ctrl.z}, {m_a, m_b, m_pc, m_z});
         end
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (dut.ctrl.addr !== 4'd0 || dut.ctrl.z !== 1'b0 || dut.a !== m_a || dut.b !== m_b) begin
         n_fail++;
         $display("FAIL async_immediate: got addr=%0d z=%b a=%h b=%h expected addr=0 z=0 a=%h b=%h",
                  dut.ctrl.addr, dut.ctrl.z, dut.a, dut.b, m_a, m_b);
      end
      m_pc = 4'd0; m_z = 1'b0; m_halt = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (dut.ctrl.addr !== 4'd0 || dut.a !== m_a || dut.b !== m_b) begin
         n_fail++;
         $display("FAIL async_held: got addr=%0d a=%h b=%h expected addr=0 a=%h b=%h",
                  dut.ctrl.addr, dut.a, dut.b, m_a, m_b);
      end
      @(negedge clk); rst = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); model_step(); #1;
         n_checks++;
         if ({dut.a, dut.b, dut.ctrl.addr, dut.ctrl.z} !== {m_a, m_b, m_pc, m_z}) begin
            n_fail++;
            $display("FAIL async_restart cyc %0d: got %h expected %h", c,
                     {dut.a, dut.b, dut.ctrl.addr, dut.ctrl.z}, {m_a, m_b, m_pc, m_z});
         end
      end
   endtask

   task automatic test_random_programs();
      logic [7:0]  p[$];
      logic [31:0] va, vb;
      for (int t = 0; t < 8; t++) begin
         p = {};
         for (int i = 0; i < 16; i++) p.push_back(8'($urandom));
         va = (t % 2 == 0) ? 32'($urandom_range(0, 4)) : $urandom;
         vb = (t % 3 == 0) ? va : 32'($urandom_range(0, 3));
         load(p, va, vb);
         for (int c = 1; c <= 40; c++) begin
            @(posedge clk); model_step(); #1;
            n_checks++;
            if ({dut.a, dut.b, dut.ctrl.addr, dut.ctrl.z, dut.ctrl.halted} !== {m_a, m_b, m_pc, m_z, m_halt}) begin
               n_fail++;
               $display("FAIL random prog %0d cyc %0d: got %h expected %h", t, c,
                        {dut.a, dut.b, dut.ctrl.addr, dut.ctrl.z, dut.ctrl.halted}, {m_a, m_b, m_pc, m_z, m_halt});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sub_wrap();
      test_equality_loop();
      test_countdown();
      test_pc_wrap();
      test_async_reset();
      test_random_programs();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
